capture_store_display: RTL and testbench
========================================

// Module: capture_store_display
// PURPOSE
//  Downstream stage of the 4-bit number-capture block.
//  - Consumes its memory-write stream (iWe/iAddr/iData) into an on-chip RAM and tracks how many entries are valid.
//  - A browse FSM steps through stored entries on iNext/iPrev pulses and multiplexes the selected 12-bit value onto a 4-digit 7-segment display.
//  - Sits between the capture stage and the board display pins.
// PARAMETERS
//  ADDR_W       10     address width; DEPTH = 2**ADDR_W entries
//  DATA_W       12     stored word width (3 hex digits)
//  REFRESH_DIV  50000  clocks per digit slot (1 kHz/digit at 50 MHz); must be >=2
// PORTS
//  iClk    in   1       system clock, all logic on rising edge
//  iRst    in   1       asynchronous reset, ACTIVE-LOW
//  iWe     in   1       write strobe from capture stage
//  iAddr   in   ADDR_W  write address
//  iData   in   DATA_W  write data
//  iNext   in   1       single-cycle pulse: show next entry
//  iPrev   in   1       single-cycle pulse: show previous entry
//  iClear  in   1       single-cycle pulse: discard all entries
//  oSeg    out  7       segments g..a, active-low
//  oAn     out  4       digit anodes, active-low one-hot (bit0 = rightmost)
//  oIdx    out  ADDR_W  index of displayed entry
//  oEmpty  out  1       1 when valid count == 0
// BEHAVIOUR
//  - Reset: oSeg=7'h7F, oAn=4'hF, oIdx=0, oEmpty=1, count=0, FSM=IDLE, refresh counter=0, digit select=0. RAM contents are not reset.
//  - Write: RAM written synchronously whenever iWe=1. If iAddr >= count, then count <= iAddr+1.
//    - count is ADDR_W+1 bits, max DEPTH.
//  - Clear: count<=0, idx<=0, FSM->IDLE.
//    - Clear beats every other event in the same cycle.
//    - A same-cycle iWe still writes RAM but is not counted.
//  - FSM states: IDLE, FETCH, SHOW.
//    - IDLE: data digits show '-' (seg g only). Leaves on the first counted write, going to FETCH with idx=0.
//    - FETCH: RAM read of idx (1-cycle latency). Next cycle the word is latched into the display register, then SHOW.
//    - SHOW, iNext: idx <= (idx==count-1) ? 0 : idx+1; go to FETCH.
//    - SHOW, iPrev: idx <= (idx==0) ? count-1 : idx-1; go to FETCH.
//    - SHOW, iNext and iPrev together: both ignored.
//    - Pulses arriving in IDLE or FETCH are dropped.
//    - SHOW, iWe with iAddr==idx: go to FETCH so the display refreshes; same-cycle iNext/iPrev are dropped.
//  - Latency: iNext at cycle n -> oIdx new value at n+1; display register new value at n+3 (n+1 enter FETCH, n+2 read, n+3 SHOW).
//  - Mux:
//    - Refresh counter counts 0..REFRESH_DIV-1.
//    - On wrap, digit select advances 0->1->2->3->0.
//    - oAn/oSeg are registered and take effect on the first wrap after reset, not before.
//    - Digits 0..2 show the value nibbles [3:0], [7:4], [11:8] as hex 0-F.
//  - oEmpty is a registered (count==0) flag, updated the cycle after count changes.
// CONFIGURATION
//  - DISP_INDEX_EN defined: digit 3 shows idx[3:0] as hex; in IDLE it shows '-'.
//  - DISP_INDEX_EN undefined: digit 3 stays blanked (its oAn bit held 1) and the scan still spends its slot.
// STRUCTURE
//  - capture_pkg holds: ADDR_W/DATA_W defaults, FSM state encodings, SEG_DASH/SEG_BLANK constants, and the hex-to-7seg function.
//  - Sub-module capture_ram: simple dual-port RAM, one write port and one registered read port; infers block RAM.
//  - Top holds the count, browse FSM and display mux.
// TESTING
//  1. Reset, wait 4*REFRESH_DIV clocks (REFRESH_DIV=4 in sim) -> oEmpty=1, oAn scans 1110,1101,1011,0111; data digits show 7'b0111111 ('-').
//  2. Write addr 0 = 12'h123 -> oEmpty=0 two cycles later, oIdx=0; digits 0..2 show 3,2,1.
//  3. Write addrs 1,2 = 12'hABC, 12'h00F -> count=3. iNext x3 -> oIdx 1,2,0 (wrap). iPrev at idx 0 -> oIdx=2.
//  4. In SHOW at idx=1, rewrite addr 1 = 12'h555 -> within 3 cycles digits show 5,5,5.
//  5. iClear with same-cycle iWe to addr 5 -> count=0, oEmpty=1, IDLE. A following iNext leaves oIdx=0.
//  6. Drop iRst to 0 mid-FETCH -> all outputs take reset values immediately, without waiting for a clock.
//     After release, a write to addr 1023 gives count=1024 (no overflow) and oIdx=0.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared defaults, browse FSM encodings and 7-segment helpers for capture_store_display.
package capture_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 12;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    // Segment vectors are g..a, active-low.
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] hexToSeg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port RAM: one write port, one registered read port (maps onto block RAM).
module capture_ram
    import capture_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              iClk,
    input  logic              iWe,
    input  logic [ADDR_W-1:0] iWrAddr,
    input  logic [DATA_W-1:0] iWrData,
    input  logic [ADDR_W-1:0] iRdAddr,
    output logic [DATA_W-1:0] oRdData
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge iClk) begin
        if (iWe)
            mem[iWrAddr] <= iWrData;
        oRdData <= mem[iRdAddr];
    end

endmodule

// File: rtl/capture_store_display.sv
// Stores the capture write stream, browses entries with iNext/iPrev and scans them onto a 4-digit display.
// Optional DISP_INDEX_EN: digit 3 shows the low nibble of the browse index instead of staying blank.
module capture_store_display
    import capture_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iWe,
    input  logic [ADDR_W-1:0] iAddr,
    input  logic [DATA_W-1:0] iData,
    input  logic              iNext,
    input  logic              iPrev,
    input  logic              iClear,
    output logic [6:0]        oSeg,
    output logic [3:0]        oAn,
    output logic [ADDR_W-1:0] oIdx,
    output logic              oEmpty
);

    localparam int RC_W = $clog2(REFRESH_DIV);
    localparam logic [RC_W-1:0]   RC_LAST   = RC_W'(REFRESH_DIV - 1);
    localparam logic [RC_W-1:0]   RC_ONE    = RC_W'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W+1)'(1);

    logic [ADDR_W:0]   countReg;
    logic [ADDR_W:0]   countM1;
    logic [ADDR_W-1:0] lastIdx;
    logic [ADDR_W-1:0] idxReg;
    logic [1:0]        stateReg;
    logic              fetchPhaseReg;
    logic [DATA_W-1:0] dispReg;
    logic [DATA_W-1:0] rdData;
    logic              emptyReg;
    logic [RC_W-1:0]   refCntReg;
    logic [1:0]        digitSelReg;
    logic [6:0]        segReg;
    logic [3:0]        anReg;
    logic              wrHitIdx;
    logic              idle;
    logic [3:0][6:0]   digitSeg;

    capture_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) uRam (
        .iClk   (iClk),
        .iWe    (iWe),
        .iWrAddr(iAddr),
        .iWrData(iData),
        .iRdAddr(idxReg),
        .oRdData(rdData)
    );

    assign countM1  = countReg - COUNT_ONE;
    assign lastIdx  = countM1[ADDR_W-1:0];
    assign wrHitIdx = iWe && (iAddr == idxReg);
    assign idle     = (stateReg == ST_IDLE);

    // count is one bit wider than the address so a full RAM reads as DEPTH, not 0.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst)
            countReg <= '0;
        else if (iClear)
            countReg <= '0;
        else if (iWe && ({1'b0, iAddr} >= countReg))
            countReg <= {1'b0, iAddr} + COUNT_ONE;
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst)
            emptyReg <= 1'b1;
        else
            emptyReg <= (countReg == '0);
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            stateReg      <= ST_IDLE;
            idxReg        <= '0;
            fetchPhaseReg <= 1'b0;
            dispReg       <= '0;
        end else if (iClear) begin
            stateReg      <= ST_IDLE;
            idxReg        <= '0;
            fetchPhaseReg <= 1'b0;
        end else begin
            case (stateReg)
                ST_IDLE: begin
                    if (iWe) begin
                        stateReg      <= ST_FETCH;
                        idxReg        <= '0;
                        fetchPhaseReg <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    // A write to the entry being fetched would race the read; reissue it.
                    if (wrHitIdx) begin
                        fetchPhaseReg <= 1'b0;
                    end else if (!fetchPhaseReg) begin
                        fetchPhaseReg <= 1'b1;
                    end else begin
                        dispReg       <= rdData;
                        stateReg      <= ST_SHOW;
                        fetchPhaseReg <= 1'b0;
                    end
                end
                ST_SHOW: begin
                    if (wrHitIdx) begin
                        stateReg <= ST_FETCH;
                    end else if (iNext && !iPrev) begin
                        stateReg <= ST_FETCH;
                        idxReg   <= (idxReg == lastIdx) ? '0 : idxReg + IDX_ONE;
                    end else if (iPrev && !iNext) begin
                        stateReg <= ST_FETCH;
                        idxReg   <= (idxReg == '0) ? lastIdx : idxReg - IDX_ONE;
                    end
                end
                default: stateReg <= ST_IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : gDataDigit
        assign digitSeg[gi] = idle ? SEG_DASH : hexToSeg(dispReg[4*gi +: 4]);
    end

`ifdef DISP_INDEX_EN
    localparam logic [3:0] AN_MASK = 4'b0000;
    assign digitSeg[3] = idle ? SEG_DASH : hexToSeg(idxReg[3:0]);
`else
    // Digit 3 keeps its scan slot but its anode is never enabled.
    localparam logic [3:0] AN_MASK = 4'b1000;
    assign digitSeg[3] = SEG_BLANK;
`endif

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            refCntReg   <= '0;
            digitSelReg <= 2'd0;
            segReg      <= SEG_BLANK;
            anReg       <= 4'hF;
        end else if (refCntReg == RC_LAST) begin
            refCntReg   <= '0;
            digitSelReg <= digitSelReg + 2'd1;
            segReg      <= digitSeg[digitSelReg];
            anReg       <= ~(4'b0001 << digitSelReg) | AN_MASK;
        end else begin
            refCntReg <= refCntReg + RC_ONE;
        end
    end

    assign oSeg   = segReg;
    assign oAn    = anReg;
    assign oIdx   = idxReg;
    assign oEmpty = emptyReg;

endmodule

// File: tb/tb_capture_store_display.sv
// Scoreboard bench for capture_store_display: expected scan frames are queued at stimulus time and popped per digit slot.
module tb_capture_store_display;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 12;
    localparam int DIV    = 4;
`ifdef DISP_INDEX_EN
    localparam bit IDX_EN = 1'b1;
`else
    localparam bit IDX_EN = 1'b0;
`endif

    logic              iClk = 1'b0;
    logic              iRst = 1'b1;
    logic              iWe = 1'b0;
    logic [ADDR_W-1:0] iAddr = '0;
    logic [DATA_W-1:0] iData = '0;
    logic              iNext = 1'b0;
    logic              iPrev = 1'b0;
    logic              iClear = 1'b0;
    logic [6:0]        oSeg;
    logic [3:0]        oAn;
    logic [ADDR_W-1:0] oIdx;
    logic              oEmpty;

    int testsRun = 0;
    int testsFailed = 0;
    int cyc = 0;

    logic [DATA_W-1:0] modelMem [0:1023];
    int                modelCount = 0;
    int                modelIdx = 0;
    bit                modelIdle = 1'b1;
    logic [10:0]       expQ [$];

    capture_store_display #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REFRESH_DIV(DIV)) dut (
        .iClk  (iClk),
        .iRst  (iRst),
        .iWe   (iWe),
        .iAddr (iAddr),
        .iData (iData),
        .iNext (iNext),
        .iPrev (iPrev),
        .iClear(iClear),
        .oSeg  (oSeg),
        .oAn   (oAn),
        .oIdx  (oIdx),
        .oEmpty(oEmpty)
    );

    always #5 iClk = ~iClk;

    // Clock edges since reset release; the display wraps on every DIV-th edge.
    always @(posedge iClk or negedge iRst) begin
        if (!iRst) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] tbSeg(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic settle();
        repeat (4) tick();
    endtask

    task automatic writeWord(input int addr, input logic [DATA_W-1:0] data);
        iWe = 1'b1; iAddr = ADDR_W'(addr); iData = data;
        tick();
        iWe = 1'b0;
        modelMem[addr] = data;
        if (addr >= modelCount) modelCount = addr + 1;
        if (modelIdle) begin modelIdle = 1'b0; modelIdx = 0; end
        $display("[TB] write addr=%0d data=0x%03h", addr, data);
    endtask

    // kind: 0 = next, 1 = prev, 2 = both; model only moves when the DUT is in SHOW.
    task automatic pulse(input int kind, input bit inShow);
        iNext = (kind != 1);
        iPrev = (kind != 0);
        tick();
        iNext = 1'b0; iPrev = 1'b0;
        if (inShow && kind == 0) modelIdx = (modelIdx == modelCount - 1) ? 0 : modelIdx + 1;
        if (inShow && kind == 1) modelIdx = (modelIdx == 0) ? modelCount - 1 : modelIdx - 1;
        $display("[TB] pulse kind=%0d oIdx=%0d", kind, oIdx);
    endtask

    task automatic pushScan();
        logic [DATA_W-1:0] w;
        logic [3:0] an;
        logic [3:0] ix;
        w = modelMem[modelIdx];
        for (int d = 0; d < 3; d++) begin
            an = ~(4'b0001 << d);
            expQ.push_back({an, modelIdle ? 7'b0111111 : tbSeg(w[4*d +: 4])});
        end
        ix = 4'(modelIdx);
        if (IDX_EN) expQ.push_back({4'b0111, modelIdle ? 7'b0111111 : tbSeg(ix)});
        else        expQ.push_back({4'hF, 7'h7F});
    endtask

    task automatic checkScan(input string tag);
        logic [10:0] exp;
        bit found;
        for (int d = 0; d < 4; d++) begin
            found = 1'b0;
            for (int i = 0; i < 8 * DIV && !found; i++) begin
                tick();
                if (cyc > 0 && cyc % DIV == 0 && ((cyc / DIV) - 1) % 4 == d) found = 1'b1;
            end
            exp = expQ.pop_front();
            if (!found) checkEq($sformatf("%s_slot%0d_timeout", tag, d), 0, 1);
            else        checkEq($sformatf("%s_digit%0d", tag, d), {21'd0, oAn, oSeg}, {21'd0, exp});
            $display("[TB] scan %s digit%0d an=%b seg=%b", tag, d, oAn, oSeg);
        end
    endtask

    initial begin
        // 1: reset values, nothing shown before the first wrap, then an idle scan.
        #2 iRst = 1'b0;
        #1;
        checkEq("rst_seg", {25'd0, oSeg}, 32'h7F);
        checkEq("rst_an", {28'd0, oAn}, 32'hF);
        checkEq("rst_idx", {22'd0, oIdx}, 0);
        checkEq("rst_empty", {31'd0, oEmpty}, 1);
        repeat (3) tick();
        iRst = 1'b1;
        repeat (DIV - 1) tick();
        checkEq("prewrap_an", {28'd0, oAn}, 32'hF);
        checkEq("prewrap_seg", {25'd0, oSeg}, 32'h7F);
        pushScan();
        checkScan("idle");

        // 2: first write leaves IDLE; empty flag drops two cycles later.
        writeWord(0, 12'h123);
        checkEq("empty_lag", {31'd0, oEmpty}, 1);
        tick();
        checkEq("empty_clr", {31'd0, oEmpty}, 0);
        checkEq("idx_first", {22'd0, oIdx}, 0);
        settle();
        pushScan();
        checkScan("w123");

        // 3: browse with wrap in both directions, dropped and conflicting pulses.
        writeWord(1, 12'hABC);
        writeWord(2, 12'h00F);
        pulse(0, 1'b1);
        checkEq("next1", {22'd0, oIdx}, 32'(modelIdx));
        pulse(0, 1'b0);
        checkEq("fetch_drop", {22'd0, oIdx}, 1);
        settle();
        pulse(0, 1'b1);
        checkEq("next2", {22'd0, oIdx}, 2);
        settle();
        pulse(2, 1'b0);
        checkEq("both_ignored", {22'd0, oIdx}, 2);
        pulse(0, 1'b1);
        checkEq("next_wrap", {22'd0, oIdx}, 0);
        settle();
        pulse(1, 1'b1);
        checkEq("prev_wrap", {22'd0, oIdx}, 2);
        settle();
        pushScan();
        checkScan("idx2");

        // 4: rewriting the shown entry refreshes the display.
        pulse(1, 1'b1);
        checkEq("prev1", {22'd0, oIdx}, 1);
        settle();
        writeWord(1, 12'h555);
        settle();
        pushScan();
        checkScan("rewrite");

        // 5: clear wins over a same-cycle write, which is stored but not counted.
        iClear = 1'b1; iWe = 1'b1; iAddr = 10'd5; iData = 12'h777;
        tick();
        iClear = 1'b0; iWe = 1'b0;
        modelMem[5] = 12'h777; modelCount = 0; modelIdx = 0; modelIdle = 1'b1;
        $display("[TB] clear with write addr=5");
        checkEq("clr_idx", {22'd0, oIdx}, 0);
        tick();
        checkEq("clr_empty", {31'd0, oEmpty}, 1);
        pulse(0, 1'b0);
        checkEq("idle_drop", {22'd0, oIdx}, 0);
        pushScan();
        checkScan("cleared");
        writeWord(0, 12'h001);
        settle();
        pulse(0, 1'b1);
        checkEq("count_one_wrap", {22'd0, oIdx}, 32'(modelIdx));
        settle();

        // 6: asynchronous reset mid-FETCH, then a write to the top address.
        writeWord(3, 12'h333);
        settle();
        pulse(0, 1'b1);
        checkEq("pre_rst_idx", {22'd0, oIdx}, 1);
        #2 iRst = 1'b0;
        #1;
        checkEq("arst_seg", {25'd0, oSeg}, 32'h7F);
        checkEq("arst_an", {28'd0, oAn}, 32'hF);
        checkEq("arst_idx", {22'd0, oIdx}, 0);
        checkEq("arst_empty", {31'd0, oEmpty}, 1);
        modelCount = 0; modelIdx = 0; modelIdle = 1'b1;
        repeat (2) tick();
        iRst = 1'b1;
        writeWord(1023, 12'h3FF);
        tick();
        checkEq("full_empty", {31'd0, oEmpty}, 0);
        checkEq("full_idx", {22'd0, oIdx}, 0);
        settle();
        pushScan();
        checkScan("after_rst");
        pulse(1, 1'b1);
        checkEq("full_prev", {22'd0, oIdx}, 1023);
        settle();
        pulse(0, 1'b1);
        checkEq("full_next_wrap", {22'd0, oIdx}, 0);
        settle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
